// File: rtl/local_ctrl_gen_pkg.sv
// local_ctrl_pkg: shared state type and width/length helpers for local_ctrl_gen
package local_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;
    function automatic int clog2_min1(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int cycles_of(input int elements, input int mac_num);
        return elements / mac_num;
    endfunction
endpackage

// File: rtl/local_ctrl_gen_if.sv
// local_ctrl_gen_if: host/buffer/MAC-array signals of local_ctrl_gen
// Ports: master = controller side (start_i/stall_i in, all *_o out); slave = the opposite view.
interface local_ctrl_gen_if #(
    parameter int A_W = 2,
    parameter int B_W = 5
);
    logic           start_i;
    logic           stall_i;
    logic           busy_o;
    logic [A_W-1:0] din1_addr_o;
    logic           din1_en_o;
    logic [B_W-1:0] din2_addr_o;
    logic           din2_en_o;
    logic           pu_en_o;
    logic           pu_clear_o;
    logic           pu_valid_o;
    logic           pu2_en_o;
    logic           done_o;
    modport master (
        input  start_i, stall_i,
        output busy_o, din1_addr_o, din1_en_o, din2_addr_o, din2_en_o,
               pu_en_o, pu_clear_o, pu_valid_o, pu2_en_o, done_o
    );
    modport slave (
        output start_i, stall_i,
        input  busy_o, din1_addr_o, din1_en_o, din2_addr_o, din2_en_o,
               pu_en_o, pu_clear_o, pu_valid_o, pu2_en_o, done_o
    );
endinterface

// File: rtl/local_ctrl_gen_delay_line.sv
// ctrl_delay_line: DEPTH-stage shift register delaying a WIDTH-bit strobe bundle
// Ports: clk_i clock; rstn_i async active-low reset (clears every stage); din_i in; dout_o = din_i delayed DEPTH cycles.
module ctrl_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;
    always_comb begin
        sr_d[0] = din_i;
        for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sr_q <= '0;
        else         sr_q <= sr_d;
    end
    assign dout_o = sr_q[DEPTH-1];
endmodule

// File: rtl/local_ctrl_gen.sv
// local_ctrl_gen: sequences din1/din2 buffer reads and MAC-array strobes for ROWS x COLUMN dot products
// Ports: clk_i clock; rstn_i async active-low reset; bus (master): start_i/stall_i in,
//        busy_o, din1/din2 address+enable, pu_en_o, pu_clear_o, pu_valid_o, pu2_en_o, done_o out.
// Build option: define LOCAL_CTRL_STALL_EN to honour stall_i; otherwise issue is strictly back-to-back.
module local_ctrl_gen
    import local_ctrl_pkg::*;
#(
    parameter int MAC_NUM  = 8,
    parameter int ELEMENTS = 32,
    parameter int COLUMN   = 8,
    parameter int ROWS     = 1,
    parameter int RD_LAT   = 1
) (
    input logic              clk_i,
    input logic              rstn_i,
    local_ctrl_gen_if.master bus
);
    localparam int CYCLES = cycles_of(ELEMENTS, MAC_NUM);
    localparam int A_W    = clog2_min1(ROWS * CYCLES);
    localparam int B_W    = clog2_min1(COLUMN * CYCLES);
    localparam int K_W    = clog2_min1(CYCLES);
    localparam int C_W    = clog2_min1(COLUMN);
    localparam int R_W    = clog2_min1(ROWS);
    localparam int D_W    = clog2_min1(RD_LAT + 2);

    state_e         state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [C_W-1:0] c_q, c_d;
    logic [R_W-1:0] r_q, r_d;
    logic [D_W-1:0] drain_q, drain_d;
    logic [A_W-1:0] a1_q, a1_d;
    logic [B_W-1:0] a2_q, a2_d;
    logic           en_q, en_d, busy_q, busy_d, done_q, done_d, pu2_q, pu2_d;
    logic           stall, k_wrap, c_wrap, last_idx, pu_valid;
    logic [1:0]     issue_dly;

`ifdef LOCAL_CTRL_STALL_EN
    assign stall = bus.stall_i;
`else
    assign stall = 1'b0;
`endif

    // k/c/r always hold the indices of the most recent issue
    assign k_wrap   = k_q == K_W'(CYCLES - 1);
    assign c_wrap   = c_q == C_W'(COLUMN - 1);
    assign last_idx = k_wrap && c_wrap && r_q == R_W'(ROWS - 1);

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        k_d     = k_q;
        c_d     = c_q;
        r_d     = r_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: if (bus.start_i) begin
                state_d = FETCH;
                en_d    = 1'b1;
            end
            FETCH: if (last_idx) begin
                state_d = DRAIN;
                drain_d = '0;
            end else if (!stall) begin
                en_d = 1'b1;
                k_d  = k_wrap ? '0 : k_q + 1'b1;
                c_d  = k_wrap ? (c_wrap ? '0 : c_q + 1'b1) : c_q;
                r_d  = (k_wrap && c_wrap) ? r_q + 1'b1 : r_q;
            end
            // last pu2_en_o leaves RD_LAT+2 cycles after the last issue
            DRAIN: if (drain_q == D_W'(RD_LAT + 1)) state_d = DONE;
                   else drain_d = drain_q + 1'b1;
            DONE: begin
                state_d = IDLE;
                k_d     = '0;
                c_d     = '0;
                r_d     = '0;
            end
        endcase
        a1_d   = A_W'(int'(r_d) * CYCLES + int'(k_d));
        a2_d   = B_W'(int'(c_d) * CYCLES + int'(k_d));
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        pu2_d  = pu_valid;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            c_q     <= '0;
            r_q     <= '0;
            drain_q <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pu2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            c_q     <= c_d;
            r_q     <= r_d;
            drain_q <= drain_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pu2_q   <= pu2_d;
        end
    end

    ctrl_delay_line #(.DEPTH(RD_LAT), .WIDTH(2)) u_issue (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .din_i  ({en_q, en_q && k_q == '0}),
        .dout_o (issue_dly)
    );
    ctrl_delay_line #(.DEPTH(RD_LAT + 1), .WIDTH(1)) u_last (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .din_i  (en_q && k_wrap),
        .dout_o (pu_valid)
    );

    assign bus.busy_o      = busy_q;
    assign bus.din1_addr_o = a1_q;
    assign bus.din1_en_o   = en_q;
    assign bus.din2_addr_o = a2_q;
    assign bus.din2_en_o   = en_q;
    assign bus.pu_en_o     = issue_dly[1];
    assign bus.pu_clear_o  = issue_dly[0];
    assign bus.pu_valid_o  = pu_valid;
    assign bus.pu2_en_o    = pu2_q;
    assign bus.done_o      = done_q;
endmodule
